narrow_store: RTL and testbench
===============================

# narrow_store

Store-path narrowing unit: the counterpart of the immediate sign extender, taking a 32-bit register value down to byte, halfword or word width for memory writes. It accepts one store request through a valid/ready handshake and checks alignment. It also flags values that cannot be represented in the narrow width. It then serialises the truncated value, little-endian, one byte per beat, onto an 8-bit memory write port, between the datapath's store stage and the byte-wide data memory.

## Interface
- N_IN, 32, width of register data (fixed at 32 for this design)
- ADDR_W, 32, memory address width
- clk  in  1  clock, all state updates on rising edge
- rstb  in  1  synchronous active-low reset, sampled on rising clk
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_data  in  N_IN  register value to store
- req_addr  in  ADDR_W  byte address of the store
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  1 = signed representability check, 0 = unsigned
- mem_we  out  1  byte write beat valid
- mem_ready  in  1  memory accepts current beat
- mem_addr  out  ADDR_W  byte address of current beat
- mem_wdata  out  8  byte data of current beat
- done  out  1  one-cycle pulse, request complete; ovf/err valid this cycle
- ovf  out  1  value not representable in requested width
- err  out  1  illegal size or misaligned address; no bytes written

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: req_ready=1. Handshake on req_valid && req_ready captures data, addr, size and signed, and computes the checks.
- err conditions: size=11; half with addr[0]=1; word with addr[1:0]!=00.
  - err set: IDLE -> DONE, no mem_we beats.
  - err clear: IDLE -> WRITE, beat count = 1 (byte), 2 (half) or 4 (word).
- ovf, signed byte: data[31:7] not all equal. Unsigned byte: data[31:8]!=0.
- ovf, signed half: data[31:15] not all equal. Unsigned half: data[31:16]!=0.
- ovf, word: ovf=0 always.
- ovf does not block the store. The truncated low bits are written regardless.
- WRITE: mem_we=1. Beat k (k from 0) drives mem_addr=addr+k (mod 2^ADDR_W) and mem_wdata=data[8k+7:8k].
- A beat completes on mem_we && mem_ready. k then increments; after the last beat the unit moves to DONE.
- DONE: done=1 for exactly one cycle with ovf/err held valid, then IDLE.
- err and ovf are mutually exclusive. err takes priority, so ovf=0 when err=1.

## Timing
- All outputs registered except req_ready, which is decoded from state.
- Reset values: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, done 0, ovf 0, err 0. req_ready=0 while rstb is low.
- ovf and err are meaningful only while done=1 and are cleared on return to IDLE.
- Latency with mem_ready tied high, request accepted at edge 0:
  - byte: beat in cycle 1, done in cycle 2.
  - half: beats in cycles 1-2, done in cycle 3.
  - word: beats in cycles 1-4, done in cycle 5.
  - err: done in cycle 1.
- Backpressure: while mem_we && !mem_ready, mem_addr and mem_wdata hold stable. Each stalled cycle adds one cycle of latency.
- Back-to-back requests: the earliest next acceptance is the cycle after done. Maximum throughput is one word per 6 cycles.
- req_valid in non-IDLE states is ignored, and the request is not captured.
- Reset mid-operation: abandon the request; mem_we=0 after the reset edge. No done pulse, and remaining bytes are not written.
- Address arithmetic is modulo 2^ADDR_W. An aligned word never crosses the top of memory.

## Test plan
- Word store, data=0x12345678, addr=0x100, mem_ready=1:
  - beats (0x100,0x78),(0x101,0x56),(0x102,0x34),(0x103,0x12).
  - done at cycle 5, ovf=0, err=0.
- Signed byte, data=0xFFFFFF80, addr=0x7: single beat (0x7,0x80), ovf=0.
- Signed byte, data=0x00000080: single beat (0x7,0x80), ovf=1.
- Unsigned half, data=0x00010000, addr=0x2:
  - beats (0x2,0x00),(0x3,0x00).
  - ovf=1, done at cycle 3.
- Half at addr=0x3, word at addr=0x6, and size=11: no mem_we, done at cycle 1, err=1, ovf=0.
- Word store with mem_ready low for 3 cycles on beat 1:
  - mem_addr/mem_wdata hold (0x101,0x56) throughout the stall.
  - done at cycle 8.
  - rstb low during beat 2 of a second word store: mem_we=0, done=0 and req_ready=0 after the reset edge; req_ready=1 once rstb is high.

Source files
------------

// File: rtl/narrow_store.sv
// narrow_store: store-path narrowing unit.
// Accepts one 32-bit register value with a byte/half/word size and checks it.
// The checks cover illegal size, misaligned address and representability in
// the narrow width. The value is then written little-endian, one byte per
// beat, onto a byte-wide memory port.
module narrow_store #(
  parameter int N_IN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_IN-1:0]   req_data,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done,
  output logic              ovf,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [N_IN-1:0]   data_q;      // bytes still to be written, next one in [7:0]
  logic [1:0]        beats_left;  // beats remaining after the one on the port
  logic              ovf_pend;    // representability result, shown at DONE

  logic              chk_err;
  logic              chk_ovf;
  logic [1:0]        chk_beats;

  // A misaligned or illegal-size request never touches memory.
  function automatic logic size_err(input logic [1:0] size,
                                    input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: size_err = 1'b0;
      SIZE_HALF: size_err = addr_lo[0];
      SIZE_WORD: size_err = (addr_lo != 2'b00);
      default:   size_err = 1'b1;
    endcase
  endfunction

  // A value fits a signed narrow width when every bit above the narrow
  // sign bit matches it. It fits an unsigned width when all those upper bits
  // are zero.
  function automatic logic value_ovf(input logic [1:0]      size,
                                     input logic            is_signed,
                                     input logic [N_IN-1:0] data);
    logic byte_s_ok;
    logic half_s_ok;
    byte_s_ok = (&data[31:7])  || !(|data[31:7]);
    half_s_ok = (&data[31:15]) || !(|data[31:15]);
    case (size)
      SIZE_BYTE: value_ovf = is_signed ? !byte_s_ok : (|data[31:8]);
      SIZE_HALF: value_ovf = is_signed ? !half_s_ok : (|data[31:16]);
      default:   value_ovf = 1'b0;
    endcase
  endfunction

  // Request acceptance is decoded from state and forced low during reset.
  assign req_ready = rstb && (state == IDLE);

  // Evaluate the checks and the beat count for the request currently offered.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    chk_beats = 2'd0;
    chk_err   = size_err(req_size, req_addr[1:0]);
    chk_ovf   = value_ovf(req_size, req_signed, req_data);
    case (req_size)
      SIZE_HALF: chk_beats = 2'd1;
      SIZE_WORD: chk_beats = 2'd3;
      default:   chk_beats = 2'd0;
    endcase
  end

  // Main controller: capture, beat sequencing with backpressure, completion pulse.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register updates from pre-edge values.
    if (!rstb) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      err        <= 1'b0;
      data_q     <= '0;
      beats_left <= '0;
      ovf_pend   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (chk_err) begin
              // Error wins over overflow; go straight to completion.
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              ovf   <= 1'b0;
            end else begin
              // First beat goes on the port in the very next cycle.
              state      <= WRITE;
              mem_we     <= 1'b1;
              mem_addr   <= req_addr;
              mem_wdata  <= req_data[7:0];
              data_q     <= req_data >> 8;
              beats_left <= chk_beats;
              ovf_pend   <= chk_ovf;
            end
          end
        end

        WRITE: begin
          // A stalled beat keeps address and data untouched.
          if (mem_ready) begin
            if (beats_left == 2'd0) begin
              state  <= DONE;
              mem_we <= 1'b0;
              done   <= 1'b1;
              ovf    <= ovf_pend;
              err    <= 1'b0;
            end else begin
              mem_addr   <= mem_addr + ADDR_ONE;
              mem_wdata  <= data_q[7:0];
              data_q     <= data_q >> 8;
              beats_left <= beats_left - 2'd1;
            end
          end
        end

        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          ovf      <= 1'b0;
          err      <= 1'b0;
          ovf_pend <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          done   <= 1'b0;
          ovf    <= 1'b0;
          err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_narrow_store.sv
// Self-checking bench for narrow_store. A request-level model predicts the
// byte beats, ovf and err from the store rules. A compare process checks the
// DUT against that model on every falling edge. Directed stores also pin
// hand-computed literals: first beat, flags and done cycle.
module tb_narrow_store;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = '0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        done;
  logic        ovf;
  logic        err;

  narrow_store #(.N_IN(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .ovf        (ovf),
    .err        (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- request-level model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } beat_t;

  beat_t exp_q[$];
  logic  exp_ovf = 1'b0;
  logic  exp_err = 1'b0;
  bit    comp_en = 1'b0;
  bit    in_flight = 1'b0;

  task automatic model_load(input logic [31:0] d, input logic [31:0] a,
                            input logic [1:0] s, input logic sg);
    longint sv;
    int     n;
    sv = longint'($signed(d));
    n  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    exp_err = (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
    if (s == 2'd0)
      exp_ovf = sg ? (sv < -128 || sv > 127) : (d > 32'd255);
    else if (s == 2'd1)
      exp_ovf = sg ? (sv < -32768 || sv > 32767) : (d > 32'd65535);
    else
      exp_ovf = 1'b0;
    if (exp_err) exp_ovf = 1'b0;
    exp_q.delete();
    if (!exp_err)
      for (int k = 0; k < n; k++) begin
        beat_t b;
        b.addr = a + 32'(k);
        b.data = 8'((d >> (8 * k)) & 32'hFF);
        exp_q.push_back(b);
      end
  endtask

  // Compare DUT outputs against the model every cycle, mid-period.
  always @(negedge clk) begin
    if (comp_en && rstb) begin
      if (in_flight) check("req_ready_busy", {31'b0, req_ready}, 32'd0);
      if (mem_we) begin
        check("beat_expected", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          check("beat_addr", mem_addr, exp_q[0].addr);
          check("beat_data", {24'b0, mem_wdata}, {24'b0, exp_q[0].data});
        end
      end
      if (done) begin
        check("done_all_beats", 32'(exp_q.size()), 32'd0);
        check("done_ovf", {31'b0, ovf}, {31'b0, exp_ovf});
        check("done_err", {31'b0, err}, {31'b0, exp_err});
      end
    end
  end

  // Retire a model beat when the DUT's beat completes on this edge.
  always @(posedge clk) begin
    if (comp_en && rstb && mem_we && mem_ready && exp_q.size() > 0)
      exp_q.delete(0);
  end

  // ---------------- directed store driver ----------------
  task automatic store(input logic [31:0] d, input logic [31:0] a,
                       input logic [1:0] s, input logic sg,
                       input int stall_beat, input int stall_n, input bit hold_valid,
                       input logic lit_ovf, input logic lit_err, input int lit_cycle,
                       input logic [31:0] lit_addr0, input logic [7:0] lit_data0);
    int w = 0;
    int cyc = 0;
    int beat = 0;
    int stall_left = stall_n;
    bit got_done = 1'b0;
    bit first_seen = 1'b0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    model_load(d, a, s, sg);
    req_data = d; req_addr = a; req_size = s; req_signed = sg; req_valid = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    in_flight = 1'b1;
    if (hold_valid) begin
      req_data = 32'hDEADBEEF; req_addr = 32'h0; req_size = 2'd2; req_signed = 1'b0;
    end else begin
      req_valid = 1'b0;
    end
    while (!got_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_we && !first_seen) begin
        first_seen = 1'b1;
        check("first_beat_addr", mem_addr, lit_addr0);
        check("first_beat_data", {24'b0, mem_wdata}, {24'b0, lit_data0});
      end
      if (done) begin
        got_done = 1'b1;
        check("done_cycle", 32'(cyc), 32'(lit_cycle));
        check("lit_ovf", {31'b0, ovf}, {31'b0, lit_ovf});
        check("lit_err", {31'b0, err}, {31'b0, lit_err});
        req_valid = 1'b0;
        in_flight = 1'b0;
      end
      if (mem_we && beat == stall_beat && stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem_ready = 1'b1;
      end
      if (mem_we && mem_ready) beat++;
    end
    check("done_seen", {31'b0, got_done}, 32'd1);
    if (!lit_err) check("first_beat_seen", {31'b0, first_seen}, 32'd1);
    mem_ready = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    rstb = 1'b1;
    comp_en = 1'b1;
    #1 check("ready_after_rst", {31'b0, req_ready}, 32'd1);
    @(negedge clk);

    //     data          addr          sz    sg  stall  hold  ovf err cyc addr0         data0
    store(32'h12345678, 32'h100,      2'd2, 0, 0, 0, 0,  0,  0,  5, 32'h100,      8'h78);
    store(32'hFFFFFF80, 32'h7,        2'd0, 1, 0, 0, 0,  0,  0,  2, 32'h7,        8'h80);
    store(32'h00000080, 32'h7,        2'd0, 1, 0, 0, 0,  1,  0,  2, 32'h7,        8'h80);
    store(32'h00010000, 32'h2,        2'd1, 0, 0, 0, 0,  1,  0,  3, 32'h2,        8'h00);
    store(32'h00001234, 32'h3,        2'd1, 0, 0, 0, 0,  0,  1,  1, 32'h0,        8'h00);
    store(32'h12345678, 32'h6,        2'd2, 0, 0, 0, 0,  0,  1,  1, 32'h0,        8'h00);
    store(32'h00000080, 32'h0,        2'd3, 1, 0, 0, 0,  0,  1,  1, 32'h0,        8'h00);
    store(32'h12345678, 32'h100,      2'd2, 0, 1, 3, 1,  0,  0,  8, 32'h100,      8'h78);
    store(32'hFFFF8000, 32'h10,       2'd1, 1, 0, 0, 0,  0,  0,  3, 32'h10,       8'h00);
    store(32'h00007FFF, 32'h4,        2'd1, 1, 0, 0, 0,  0,  0,  3, 32'h4,        8'hFF);
    store(32'h00000100, 32'hFFFFFFFF, 2'd0, 0, 0, 0, 0,  1,  0,  2, 32'hFFFFFFFF, 8'h00);
    store(32'hCAFEF00D, 32'hFFFFFFFC, 2'd2, 1, 0, 0, 0,  0,  0,  5, 32'hFFFFFFFC, 8'h0D);

    // Reset during beat 2 of a word store
    @(negedge clk);
    model_load(32'hA1B2C3D4, 32'h200, 2'd2, 1'b0);
    req_data = 32'hA1B2C3D4; req_addr = 32'h200; req_size = 2'd2; req_signed = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    in_flight = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_beat2_addr", mem_addr, 32'h202);
    rstb = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_req_ready", {31'b0, req_ready}, 32'd0);
    exp_q.delete();
    in_flight = 1'b0;
    rstb = 1'b1;
    #1 check("rst_mid_ready_back", {31'b0, req_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_done", {31'b0, done}, 32'd0);
      check("rst_mid_no_we", {31'b0, mem_we}, 32'd0);
    end

    // Recovery after the abandoned request
    store(32'h0000007F, 32'h55,       2'd0, 1, 0, 0, 0,  0,  0,  2, 32'h55,       8'h7F);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
